// File: rtl/operand_seq_pkg.sv
// rtl/operand_seq_pkg.sv - shared stage encoding for the operand sequencer
// Purpose: state typedef and stage width shared by the sequencer top and its bench.
// Contents: STAGE_W, state_t {S_LOAD_A, S_LOAD_B, S_EXEC, S_SHOW}
package operand_seq_pkg;

   localparam int STAGE_W = 2;

   typedef enum logic [STAGE_W-1:0] {
      S_LOAD_A = 2'd0,
      S_LOAD_B = 2'd1,
      S_EXEC   = 2'd2,
      S_SHOW   = 2'd3
   } state_t;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button synchroniser, debouncer and press pulse
// Purpose: turns a raw, bouncing, asynchronous button into a one-cycle pulse per clean press.
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   btn_raw      in   unsynchronised button level, active-high
//   press_pulse  out  registered one-cycle pulse when the debounced level rises
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic press_pulse
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic             stable;
   logic [CNT_W-1:0] counter;

   // The counter only runs while the synchronised level disagrees with the
   // accepted level; any return to the accepted level restarts the window.
   // Clearing at the terminal count means the counter can never wrap.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1       <= 1'b0;
         sync2       <= 1'b0;
         stable      <= 1'b0;
         counter     <= '0;
         press_pulse <= 1'b0;
      end else begin
         sync1       <= btn_raw;
         sync2       <= sync1;
         press_pulse <= 1'b0;
         if (sync2 == stable) begin
            counter <= '0;
         end else if (counter == CNT_LAST) begin
            stable      <= sync2;
            counter     <= '0;
            // only a 0->1 acceptance is a press; release is silent
            press_pulse <= sync2;
         end else begin
            counter <= counter + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/operand_sequencer.sv
// rtl/operand_sequencer.sv - button-stepped operand loader and ALU execute strobe
// Purpose: each clean press loads the switch byte into A, then B, then fires exec_pulse.
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   btn_raw      in   raw centre button, active-high
//   clear        in   synchronous abort, active-high
//   sw_bits      in   operand value from switches
//   a_val        out  latched operand A
//   b_val        out  latched operand B
//   exec_pulse   out  one-cycle strobe while in S_EXEC
//   press_pulse  out  one-cycle clean press indication
//   stage        out  current state encoding
module operand_sequencer
   import operand_seq_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int DATA_W          = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               btn_raw,
   input  logic               clear,
   input  logic [DATA_W-1:0]  sw_bits,
   output logic [DATA_W-1:0]  a_val,
   output logic [DATA_W-1:0]  b_val,
   output logic               exec_pulse,
   output logic               press_pulse,
   output logic [STAGE_W-1:0] stage
);

   state_t              state;
   state_t              state_nxt;
   logic [DATA_W-1:0]   a_nxt;
   logic [DATA_W-1:0]   b_nxt;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk         (clk),
      .reset       (reset),
      .btn_raw     (btn_raw),
      .press_pulse (press_pulse)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_LOAD_A;
         a_val <= '0;
         b_val <= '0;
      end else begin
         state <= state_nxt;
         a_val <= a_nxt;
         b_val <= b_nxt;
      end
   end

   // clear wins over everything, including the S_EXEC -> S_SHOW step, so an
   // aborted run never produces a second strobe.
   always_comb begin
      state_nxt = state;
      a_nxt     = a_val;
      b_nxt     = b_val;
      if (clear) begin
         state_nxt = S_LOAD_A;
         a_nxt     = '0;
         b_nxt     = '0;
      end else begin
         case (state)
            S_LOAD_A: begin
               if (press_pulse) begin
                  a_nxt     = sw_bits;
                  state_nxt = S_LOAD_B;
               end
            end
            S_LOAD_B: begin
               if (press_pulse) begin
                  b_nxt     = sw_bits;
                  state_nxt = S_EXEC;
               end
            end
            S_EXEC: begin
               state_nxt = S_SHOW;
            end
            S_SHOW: begin
               if (press_pulse) begin
                  state_nxt = S_LOAD_A;
               end
            end
            default: begin
               state_nxt = S_LOAD_A;
            end
         endcase
      end
   end

   // Moore decode of the registered state: glitch-free, exactly one cycle.
   assign exec_pulse = (state == S_EXEC);
   assign stage      = state;

endmodule

// File: tb/tb_operand_sequencer.sv
// tb/tb_operand_sequencer.sv - randomized model-checked bench for operand_sequencer
module tb_operand_sequencer;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       btn_raw = 1'b0;
   logic       clear = 1'b0;
   logic [7:0] sw_bits = 8'h00;
   logic [7:0] a_val;
   logic [7:0] b_val;
   logic       exec_pulse;
   logic       press_pulse;
   logic [1:0] stage;

   int n_checks = 0;
   int n_fail   = 0;
   int exec_seen = 0;

   // reference model state
   int         m_stage  = 0;
   logic [7:0] m_a      = 8'h00;
   logic [7:0] m_b      = 8'h00;
   bit         m_press  = 1'b0;
   bit         m_stable = 1'b0;
   int         edge_no  = 0;
   int         last_flip = 0;
   bit         hist[$];

   operand_sequencer #(
      .DEBOUNCE_CYCLES (N),
      .DATA_W          (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_raw     (btn_raw),
      .clear       (clear),
      .sw_bits     (sw_bits),
      .a_val       (a_val),
      .b_val       (b_val),
      .exec_pulse  (exec_pulse),
      .press_pulse (press_pulse),
      .stage       (stage)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the accepted level flips at an edge when the synchronised samples
   // seen at the last N edges all disagree with it and none of those edges
   // precedes the previous flip. Sample taken at edge e reaches the compare at e+2.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_stage = 0; m_a = 0; m_b = 0; m_press = 0;
         m_stable = 0; edge_no = 0; last_flip = 0;
         hist.delete();
      end else begin
         bit flip;
         if (clear) begin
            m_stage = 0; m_a = 0; m_b = 0;
         end else begin
            case (m_stage)
               0: if (m_press) begin m_a = sw_bits; m_stage = 1; end
               1: if (m_press) begin m_b = sw_bits; m_stage = 2; end
               2: m_stage = 3;
               default: if (m_press) m_stage = 0;
            endcase
         end
         edge_no++;
         hist.push_back(btn_raw);
         flip = (edge_no - last_flip >= N);
         for (int i = 0; i < N; i++) begin
            int idx;
            bit v;
            idx = edge_no - 2 - i;
            v = (idx >= 1) ? hist[idx-1] : 1'b0;
            if (v == m_stable) flip = 1'b0;
         end
         m_press = 1'b0;
         if (flip) begin
            m_stable  = !m_stable;
            last_flip = edge_no;
            m_press   = m_stable;
         end
      end
   end

   always @(negedge clk) begin
      check("stage", 32'(stage), 32'(m_stage));
      check("a_val", 32'(a_val), 32'(m_a));
      check("b_val", 32'(b_val), 32'(m_b));
      check("exec_pulse", 32'(exec_pulse), 32'(m_stage == 2));
      check("press_pulse", 32'(press_pulse), 32'(m_press));
      if (exec_pulse) exec_seen++;
   end

   task automatic press(input logic [7:0] v);
      @(negedge clk);
      sw_bits = v;
      btn_raw = 1'b1;
      repeat (10) @(negedge clk);
      btn_raw = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         sw_bits = 8'($urandom);
      end
   endtask

   initial begin
      int presses;
      int first_at;
      int ex0;
      int run;

      repeat (3) @(negedge clk);
      reset = 1'b1;

      // press latency: single pulse after edge N+2, none on release
      btn_raw = 1'b1;
      presses = 0;
      first_at = 0;
      for (int i = 1; i <= 30; i++) begin
         @(posedge clk);
         #1;
         if (press_pulse) begin
            presses++;
            if (first_at == 0) first_at = i;
         end
         if (i == 20) btn_raw = 1'b0;
      end
      check("press_count", 32'(presses), 32'd1);
      check("press_edge", 32'(first_at), 32'd6);
      @(negedge clk);
      // the accepted press moved the FSM to S_LOAD_B with a sampled sw of 0
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;

      // bounce: 3 high, 1 low, 3 high, then low -> no press
      presses = 0;
      btn_raw = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (press_pulse) presses++;
         if (i == 2) btn_raw = 1'b0;
         if (i == 3) btn_raw = 1'b1;
         if (i == 6) btn_raw = 1'b0;
      end
      check("bounce_press_count", 32'(presses), 32'd0);
      check("bounce_stage", 32'(stage), 32'd0);

      // asynchronous reset mid-sequence
      press(8'h3C);
      check("pre_reset_a", 32'(a_val), 32'h3C);
      check("pre_reset_stage", 32'(stage), 32'd1);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("async_reset_a", 32'(a_val), 32'h0);
      check("async_reset_b", 32'(b_val), 32'h0);
      check("async_reset_stage", 32'(stage), 32'd0);
      check("async_reset_exec", 32'(exec_pulse), 32'd0);
      check("async_reset_press", 32'(press_pulse), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // full sequence
      press(8'hA5);
      check("seq_a", 32'(a_val), 32'hA5);
      check("seq_stage_b", 32'(stage), 32'd1);
      ex0 = exec_seen;
      press(8'h0F);
      check("seq_exec_count", 32'(exec_seen - ex0), 32'd1);
      check("seq_b", 32'(b_val), 32'h0F);
      check("seq_stage_show", 32'(stage), 32'd3);

      // S_SHOW press returns to load A with operands kept
      press(8'h77);
      check("show_stage", 32'(stage), 32'd0);
      check("show_a_kept", 32'(a_val), 32'hA5);
      check("show_b_kept", 32'(b_val), 32'h0F);
      press(8'h11);
      check("reload_a", 32'(a_val), 32'h11);
      check("reload_stage", 32'(stage), 32'd1);

      // clear on the same edge the press is consumed in S_LOAD_B
      ex0 = exec_seen;
      @(negedge clk);
      sw_bits = 8'hEE;
      btn_raw = 1'b1;
      repeat (6) @(negedge clk);
      check("clear_press_visible", 32'(press_pulse), 32'd1);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clear_stage", 32'(stage), 32'd0);
      check("clear_a", 32'(a_val), 32'h0);
      check("clear_b", 32'(b_val), 32'h0);
      repeat (4) @(negedge clk);
      btn_raw = 1'b0;
      repeat (10) @(negedge clk);
      check("clear_no_exec", 32'(exec_seen - ex0), 32'd0);

      // randomized run against the model
      run = 0;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         if (run == 0) begin
            btn_raw = ~btn_raw;
            run = int'($urandom_range(1, 9));
         end
         run--;
         sw_bits = 8'($urandom);
         clear = ($urandom_range(0, 39) == 0);
      end
      clear = 1'b0;
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
